// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
// funct3 codes, the IDLE/RESP state type and the access-decode helpers
// (size, legality, byte enables, load extension).
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Access size in bytes; 0 marks a size code with no meaning (x11).
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // raw holds the bytes at addr..addr+3 in little-endian order.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      F3_B:    return {{24{raw[7]}}, raw[7:0]};
      F3_H:    return {{16{raw[15]}}, raw[15:0]};
      F3_W:    return raw;
      F3_BU:   return {24'h0, raw[7:0]};
      F3_HU:   return {16'h0, raw[15:0]};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load-store unit and dmem_ctrl.
// master: drives req_* and rsp_ready; slave: drives req_ready and rsp_*.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte-addressable storage for dmem_ctrl.
// Ports: clk; wr_be (4 lanes, lane k writes addr+k); addr; wdata (lane k in
// bits [8k+7:8k]); rdata (bytes addr..addr+3, combinational).
// Lane addresses wrap modulo DEPTH_BYTES; the controller range-checks first.
// Contents are never reset.
module dmem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 4096,
  localparam int unsigned AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem_q [DEPTH_BYTES];

  // Write port: each enabled lane lands on its own consecutive byte.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) begin
        mem_q[addr + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  // Read port: four consecutive bytes starting at addr.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = mem_q[addr + AW'(k)];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-cycle data-memory controller with valid/ready request and response.
// Ports: CLK; RST (synchronous, active-high); bus (dmem_if.slave) carrying
// req_valid/ready/we/funct3/addr/wdata and rsp_valid/ready/rdata/fault.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword
// and word accesses; otherwise they complete byte-wise in one cycle.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic  CLK,
  input  logic  RST,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  state_e        state_q, state_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_fault_q, rsp_fault_d;

  logic [ADDR_W-1:0] req_addr;
  logic          req_ready;
  logic          accept;
  logic [2:0]    size;
  logic [63:0]   last_byte;
  logic          range_err;
  logic          misalign;
  logic          fault;
  logic [3:0]    wr_be;
  logic [31:0]   rd_raw;

  assign req_addr = bus.req_addr;

  // Reset blocks acceptance so nothing commits during RST.
  assign req_ready = !RST && ((state_q == IDLE) || bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;

  // Access decode: legality, range and (optionally) alignment.
  always_comb begin
    size      = size_bytes(bus.req_funct3);
    last_byte = 64'(req_addr) + 64'(size) - 64'd1;
    range_err = (last_byte >= 64'(DEPTH_BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign  = ((size == 3'd2) && req_addr[0]) ||
                ((size == 3'd4) && (req_addr[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    fault     = !f3_legal(bus.req_funct3, bus.req_we) || range_err || misalign;
  end

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk  (CLK),
    .wr_be(wr_be),
    .addr (req_addr[AW-1:0]),
    .wdata(bus.req_wdata),
    .rdata(rd_raw)
  );

  // Next-state and response capture; the array read sees pre-edge contents.
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    wr_be       = 4'b0000;
    if (accept) begin
      state_d     = RESP;
      rsp_fault_d = fault;
      rsp_rdata_d = (fault || bus.req_we) ? 32'h0 : load_ext(bus.req_funct3, rd_raw);
      if (bus.req_we && !fault) begin
        wr_be = byte_en(bus.req_funct3);
      end
    end else if ((state_q == RESP) && bus.rsp_ready) begin
      state_d     = IDLE;
      rsp_rdata_d = 32'h0;
      rsp_fault_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (DEPTH_BYTES 4096, ADDR_W 32).
module tb_dmem_ctrl;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  vec_t vecs[$];

  dmem_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(
    .DEPTH_BYTES(4096),
    .ADDR_W     (32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] er, input logic ef);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd;
    v.exp_rdata = er; v.exp_fault = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One transaction with rsp_ready high; ready wait is bounded.
  task automatic run_vec(input vec_t v);
    int n;
    drive(v.we, v.f3, v.addr, v.wdata);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk({v.name, "_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk({v.name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({v.name, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({v.name, "_fault"}, 32'(bus.rsp_fault), 32'(v.exp_fault));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;

    // Vector table: {name, we, funct3, addr, wdata, exp_rdata, exp_fault}
    add("sw_10",      1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
    add("lw_10",      0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    add("lb_10",      0, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, 0);
    add("lbu_13",     0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 0);
    add("lh_12",      0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 0);
    add("lhu_10",     0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 0);
    add("lb_11",      0, 3'b000, 32'h11,   32'h0,        32'hFFFFFFBE, 0);
    add("lw_ffe",     0, 3'b010, 32'hFFE,  32'h0,        32'h0,        1);
    add("sb_f3_100",  1, 3'b100, 32'h10,   32'h55,       32'h0,        1);
    add("sh_f3_101",  1, 3'b101, 32'h10,   32'h77,       32'h0,        1);
    add("lw_after",   0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
    add("ld_f3_011",  0, 3'b011, 32'h0,    32'h0,        32'h0,        1);
    add("ld_f3_110",  0, 3'b110, 32'h0,    32'h0,        32'h0,        1);
    add("st_f3_111",  1, 3'b111, 32'h0,    32'h0,        32'h0,        1);
    add("sw_ffc",     1, 3'b010, 32'hFFC,  32'h12345678, 32'h0,        0);
    add("lw_ffc",     0, 3'b010, 32'hFFC,  32'h0,        32'h12345678, 0);
    add("lbu_fff",    0, 3'b100, 32'hFFF,  32'h0,        32'h00000012, 0);
    add("lh_ffe",     0, 3'b001, 32'hFFE,  32'h0,        32'h00001234, 0);
    add("lh_fff",     0, 3'b001, 32'hFFF,  32'h0,        32'h0,        1);
    add("lw_1010",    0, 3'b010, 32'h1010, 32'h0,        32'h0,        1);
    add("sb_14",      1, 3'b000, 32'h14,   32'hFFFFFF80, 32'h0,        0);
    add("lb_14",      0, 3'b000, 32'h14,   32'h0,        32'hFFFFFF80, 0);
    add("sw_20",      1, 3'b010, 32'h20,   32'h0,        32'h0,        0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add("sh_21",      1, 3'b001, 32'h21,   32'hABCD1234, 32'h0,        1);
    add("lhu_21",     0, 3'b101, 32'h21,   32'h0,        32'h0,        1);
    add("lw_20_chk",  0, 3'b010, 32'h20,   32'h0,        32'h0,        0);
    add("sw_31",      1, 3'b010, 32'h31,   32'hCAFEF00D, 32'h0,        1);
    add("lw_31",      0, 3'b010, 32'h31,   32'h0,        32'h0,        1);
`else
    add("sh_21",      1, 3'b001, 32'h21,   32'hABCD1234, 32'h0,        0);
    add("lhu_21",     0, 3'b101, 32'h21,   32'h0,        32'h00001234, 0);
    add("lw_20_chk",  0, 3'b010, 32'h20,   32'h0,        32'h00123400, 0);
    add("sw_31",      1, 3'b010, 32'h31,   32'hCAFEF00D, 32'h0,        0);
    add("lw_31",      0, 3'b010, 32'h31,   32'h0,        32'hCAFEF00D, 0);
`endif

    // Reset state
    repeat (2) tick();
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    RST = 1'b0;
    #1;
    chk("rst_ready_after", 32'(bus.req_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Drain to IDLE
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    tick();
    chk("drain_valid", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: response held and stable while rsp_ready is low
    drive(0, 3'b010, 32'h10, 32'h0);
    bus.rsp_ready = 1'b0;
    tick();
    drive(0, 3'b000, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(bus.req_ready), 32'd1);
    tick();
    chk("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_next_rdata", bus.rsp_rdata, 32'hFFFFFFEF);
    bus.req_valid = 1'b0;
    tick();
    chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Back-to-back store then load to the same address
    drive(1, 3'b010, 32'h40, 32'h11223344);
    tick();
    chk("b2b_st_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_st_rdata", bus.rsp_rdata, 32'h0);
    drive(0, 3'b010, 32'h40, 32'h0);
    tick();
    chk("b2b_ld_rdata", bus.rsp_rdata, 32'h11223344);
    bus.req_valid = 1'b0;
    tick();

    // Reset while a load response is held; a store offered during RST is dropped
    drive(0, 3'b010, 32'h10, 32'h0);
    bus.rsp_ready = 1'b0;
    tick();
    chk("rh_held_valid", 32'(bus.rsp_valid), 32'd1);
    drive(1, 3'b010, 32'h10, 32'h0);
    RST = 1'b1;
    #1;
    chk("rh_ready_in_rst", 32'(bus.req_ready), 32'd0);
    tick();
    chk("rh_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rh_rdata", bus.rsp_rdata, 32'h0);
    RST = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rh_ready_after", 32'(bus.req_ready), 32'd1);
    begin
      vec_t v;
      v.name = "rh_lw_10"; v.we = 0; v.f3 = 3'b010; v.addr = 32'h10; v.wdata = 32'h0;
      v.exp_rdata = 32'hDEADBEEF; v.exp_fault = 0;
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
